// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter and sequencer sharing one 32-bit
// ALU (AND/OR/ADD/SUB/SLT) between two issue ports.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req0_valid/op/a/b          requester 0 operation (held until req0_ready)
//   req0_ready                 one-cycle accept pulse for requester 0
//   req1_valid/op/a/b          requester 1 operation (held until req1_ready)
//   req1_ready                 one-cycle accept pulse for requester 1
//   res_valid, res_ready       backpressured result handshake
//   res_id                     requester that issued the operation
//   res_data                   ALU result
//   res_set                    set-less-than flag (SUB/SLT)
//   res_carry                  adder carry-out (ADD/SUB/SLT)
//   res_err                    illegal op code

module alu_share_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,

    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic [31:0] res_data,
    output logic        res_set,
    output logic        res_carry,
    output logic        res_err
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Priority pointer: the requester favoured when both are valid.
    logic ptr;

    // Operands latched at accept time.
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        id_q;

    // Grant decode.
    logic accept;
    logic gnt_id;

    // ALU combinational results.
    logic [32:0] sum;
    logic [32:0] diff;
    logic        ovf;
    logic        slt;
    logic [31:0] alu_data;
    logic        alu_set;
    logic        alu_carry;
    logic        alu_err;

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        gnt_id     = 1'b0;
        res_valid  = 1'b0;

        unique case (state)
            IDLE: begin
                // Readys are gated by reset so nothing is accepted
                // while the block is being cleared.
                if (!reset && (req0_valid || req1_valid)) begin
                    accept = 1'b1;
                    if (req0_valid && req1_valid) begin
                        gnt_id = ptr;
                    end else begin
                        gnt_id = req1_valid;
                    end
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping and operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= 1'b0;
            op_q <= 3'b000;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            id_q <= 1'b0;
        end else if (accept) begin
            ptr  <= ~gnt_id;
            id_q <= gnt_id;
            if (gnt_id) begin
                op_q <= req1_op;
                a_q  <= req1_a;
                b_q  <= req1_b;
            end else begin
                op_q <= req0_op;
                a_q  <= req0_a;
                b_q  <= req0_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU on the latched operands
    // ------------------------------------------------------------------
    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
        // Signed overflow of A-B: operand signs differ and the
        // result sign disagrees with A.
        ovf  = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
        slt  = diff[31] ^ ovf;

        alu_data  = 32'd0;
        alu_set   = 1'b0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;

        unique case (op_q)
            OP_AND: begin
                alu_data = a_q & b_q;
            end
            OP_OR: begin
                alu_data = a_q | b_q;
            end
            OP_ADD: begin
                alu_data  = sum[31:0];
                alu_carry = sum[32];
            end
            OP_SUB: begin
                alu_data  = diff[31:0];
                alu_carry = diff[32];
                alu_set   = slt;
            end
            OP_SLT: begin
                alu_data  = {31'd0, slt};
                alu_carry = diff[32];
                alu_set   = slt;
            end
            default: begin
                alu_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers: loaded in EXEC, held through RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            res_id    <= 1'b0;
            res_data  <= 32'd0;
            res_set   <= 1'b0;
            res_carry <= 1'b0;
            res_err   <= 1'b0;
        end else if (state == EXEC) begin
            res_id    <= id_q;
            res_data  <= alu_data;
            res_set   <= alu_set;
            res_carry <= alu_carry;
            res_err   <= alu_err;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed table-driven bench for alu_share_arbiter
// plus hand-written reset, contention, backpressure and abort sequences.

module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_id;
    logic [31:0] res_data;
    logic        res_set;
    logic        res_carry;
    logic        res_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data),
        .res_set    (res_set),
        .res_carry  (res_carry),
        .res_err    (res_err)
    );

    typedef struct {
        logic        who;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        s;
        logic        c;
        logic        e;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op    = 3'b000;
        req1_op    = 3'b000;
        req0_a     = 32'd0;
        req0_b     = 32'd0;
        req1_a     = 32'd0;
        req1_b     = 32'd0;
    endtask

    task automatic drive(input logic who, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            req1_valid = 1'b1;
            req1_op    = op;
            req1_a     = a;
            req1_b     = b;
        end else begin
            req0_valid = 1'b1;
            req0_op    = op;
            req0_a     = a;
            req0_b     = b;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic got;
        logic mine;
        logic other;
        got = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        drive(v.who, v.op, v.a, v.b);
        for (int k = 0; k < 10; k++) begin
            #1;
            mine = v.who ? req1_ready : req0_ready;
            if (mine) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_accept", idx), {31'd0, got}, 32'd1);
        if (!got) begin
            idle_inputs();
            return;
        end
        other = v.who ? req0_ready : req1_ready;
        chk($sformatf("v%0d_other_ready", idx), {31'd0, other}, 32'd0);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d_exec_valid", idx), {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_valid", idx), {31'd0, res_valid}, 32'd1);
        chk($sformatf("v%0d_id", idx), {31'd0, res_id}, {31'd0, v.who});
        chk($sformatf("v%0d_data", idx), res_data, v.d);
        chk($sformatf("v%0d_set", idx), {31'd0, res_set}, {31'd0, v.s});
        chk($sformatf("v%0d_carry", idx), {31'd0, res_carry}, {31'd0, v.c});
        chk($sformatf("v%0d_err", idx), {31'd0, res_err}, {31'd0, v.e});
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   gq[$];
        int   iq[$];
        int   cyc;

        //           who  op      a             b             d             s     c     e
        tbl[0]  = '{1'b0, 3'b010, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'b111, 32'h00000006, 32'h00000008, 32'h00000001, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'b001, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'b110, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1};

        // Reset with both requesters valid.
        reset     = 1'b1;
        res_ready = 1'b0;
        idle_inputs();
        drive(1'b0, 3'b010, 32'd1, 32'd1);
        drive(1'b1, 3'b010, 32'd2, 32'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
            chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
            chk("rst_valid", {31'd0, res_valid}, 32'd0);
            chk("rst_data", res_data, 32'd0);
            chk("rst_flags", {28'd0, res_id, res_set, res_carry, res_err}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1 idle_inputs();
        res_ready = 1'b1;
        repeat (4) @(negedge clk);
        res_ready = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 12; i++) begin
            run_vec(tbl[i], i);
        end

        // Contention: both valid, consumer always ready.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(1'b0, 3'b010, 32'd1, 32'd2);
        drive(1'b1, 3'b010, 32'd10, 32'd20);
        res_ready = 1'b1;
        reset     = 1'b0;
        cyc = 0;
        while (iq.size() < 6 && cyc < 60) begin
            #1;
            chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            if (res_valid) begin
                iq.push_back(int'(res_id));
                chk("cont_data", res_data, res_id ? 32'd30 : 32'd3);
            end
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        res_ready = 1'b0;
        chk("cont_resp_count", iq.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < gq.size()) begin
                chk($sformatf("grant%0d", i), gq[i], i % 2);
            end
            if (i < iq.size()) begin
                chk($sformatf("resid%0d", i), iq[i], i % 2);
            end
        end
        repeat (2) @(negedge clk);

        // Backpressure with requester 1 waiting.
        drive(1'b0, 3'b010, 32'h11111111, 32'h22222222);
        #1 chk("bp_accept0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1 idle_inputs();
        drive(1'b1, 3'b001, 32'h000000A0, 32'h0000000B);
        @(negedge clk);
        chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        chk("bp_valid", {31'd0, res_valid}, 32'd1);
        chk("bp_data", res_data, 32'h33333333);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid%0d", i), {31'd0, res_valid}, 32'd1);
            chk($sformatf("bp_hold_data%0d", i), res_data, 32'h33333333);
            chk($sformatf("bp_hold_ready1_%0d", i), {31'd0, req1_ready}, 32'd0);
        end
        res_ready = 1'b1;
        #1 chk("bp_resp_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk("bp_idle_ready1", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("bp2_valid", {31'd0, res_valid}, 32'd1);
        chk("bp2_id", {31'd0, res_id}, 32'd1);
        chk("bp2_data", res_data, 32'h000000AB);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;

        // Reset during EXEC aborts the operation.
        @(negedge clk);
        drive(1'b0, 3'b010, 32'd5, 32'd6);
        #1 chk("abort_accept", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_data", res_data, 32'd0);
        reset     = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", i), {31'd0, res_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 32-bit ALU (AND/OR/ADD/SUB/SLT) between two requesters. It accepts one operation at a time over a valid/ready handshake, computes the result from registered operands, and returns it over a backpressured response channel tagged with the requester id. It sits between the two instruction-issue ports and the single ALU/set-less-than datapath.

## Interface
- Parameters: none. Data width is fixed at 32.
- Reset is synchronous and active-high. There is one clock.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  3  ALU control code.
- req0_a  in  32  operand A.
- req0_b  in  32  operand B.
- req0_ready  out  1  one-cycle accept pulse for requester 0.
- req1_valid / req1_op / req1_a / req1_b / req1_ready: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_id  out  1  requester that issued the operation.
- res_data  out  32  ALU result.
- res_set  out  1  set-less-than flag.
- res_carry  out  1  adder carry-out.
- res_err  out  1  illegal op code.

## Operation
- Op codes:
  - 000: AND.
  - 001: OR.
  - 010: ADD, A+B.
  - 110: SUB, A+~B+1.
  - 111: SLT (signed).
  - All other codes: illegal. res_data=0, res_err=1, set=0, carry=0.
- res_carry:
  - ADD: bit 32 of A+B.
  - SUB and SLT: bit 32 of A+~B+1.
  - Logic ops: 0.
- set = diff[31] XOR overflow, where diff=A-B and overflow = (A[31]≠B[31]) & (diff[31]≠A[31]).
  - SLT: res_data = {31'b0, set}, res_set = set.
  - SUB: res_set = set.
  - Other ops: res_set = 0.
- Arithmetic wraps modulo 2^32.
- State machine, reset state IDLE:
  - IDLE: if any reqN_valid, grant one requester and assert its reqN_ready combinationally in this cycle. Latch op, a, b and the grant id. Go to EXEC. With no valid, stay in IDLE.
  - EXEC: compute from the latched operands. Register res_data, res_set, res_carry, res_err and res_id. Go to RESP.
  - RESP: res_valid=1. All res_* outputs hold stable. When res_ready=1, go to IDLE.
- Arbitration:
  - A 1-bit priority pointer, reset value 0, selects which requester wins when both are valid.
  - When only one requester is valid, it wins regardless of the pointer.
  - After a grant to requester i, the pointer becomes ~i.
- Handshake:
  - A requester holds valid, op, a and b stable until it sees its ready.
  - reqN_ready is never high outside IDLE.
  - At most one reqN_ready is high in any cycle.
- Reset mid-operation: any in-flight operation is discarded and produces no response. The pointer returns to 0.

## Timing
- Reset values: state=IDLE, pointer=0, res_valid=0, res_id=0, res_data=0, res_set=0, res_carry=0, res_err=0. req0_ready and req1_ready are 0 whenever reset is high.
- Latency:
  - Accept at cycle N (ready high in IDLE).
  - EXEC at N+1.
  - res_valid first high at N+2.
- Throughput: one operation per 3 cycles when res_ready is held at 1. The response is consumed at N+2 (RESP→IDLE at the N+2/N+3 edge), and the next accept is possible at N+3.
- Backpressure: while res_ready=0 in RESP:
  - res_valid and res_* hold indefinitely.
  - No new request is accepted.
- A requester that drops valid before ready is not served. No stale operands are latched.

## Test plan
- Reset: assert reset for 2 cycles with both requesters valid.
  - All outputs 0 and both readys 0 while reset is high.
  - After release, req0 is granted first.
- Single ADD: req0 op=010, A=0x00000001, B=0x00000000.
  - req0_ready at cycle N.
  - At N+2: res_valid=1, res_id=0, res_data=0x00000001, carry=0, err=0.
- SLT cases:
  - A=0x00000006, B=0x00000008 → res_data=1, set=1.
  - A=0xFFFFFFFF, B=0x00000001 → set=1.
  - A=0x00000001, B=0xFFFFFFFF → set=0, res_data=0.
  - A=0x80000000, B=0x00000001 → set=1 (overflow case).
- Contention: both requesters continuously valid with res_ready=1 for 6 operations.
  - Grants alternate 0,1,0,1,0,1.
  - res_id matches the grant order.
  - No cycle has both readys high.
- Backpressure: hold res_ready=0 for 5 cycles in RESP with req1 valid.
  - res_valid stays 1 and res_data stays stable.
  - req1_ready stays 0.
  - After res_ready=1, req1 is accepted on the next IDLE cycle.
- Edge ops and reset abort:
  - ADD 0xFFFFFFFF+0x00000001 → res_data=0, carry=1.
  - op=011 → res_err=1, res_data=0.
  - Reset asserted during EXEC → res_valid=0 the following cycle, and no response appears for the aborted operation.
